step_counter: RTL and testbench

STEP_COUNTER -- requirements
Module: step_counter

---
 rtl/step_counter_pkg.sv | 12 +
 rtl/step_counter_if.sv | 27 ++
 rtl/step_addsub.sv | 54 +++++
 rtl/step_counter.sv | 62 ++++++
 tb/tb_step_counter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/step_counter_pkg.sv
// Shared constants for the step counter: saturation modes and parameter legality.
package step_counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  function automatic bit params_ok(input int width, input int step_w, input int saturate);
    return (width >= 2) && (width <= 32) && (step_w >= 1) && (step_w <= width) &&
           ((saturate == MODE_WRAP) || (saturate == MODE_SAT));
  endfunction

endpackage

// File: rtl/step_counter_if.sv
// Control/status bundle between a step counter and whoever drives it.
interface step_counter_if #(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 4
);
  logic              clr;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic              inc;
  logic              dec;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  limit;
  logic [WIDTH-1:0]  count;
  logic              cout;
  logic              tc;
  logic              zero;

  modport master (
    output clr, load, load_val, inc, dec, step, limit,
    input  count, cout, tc, zero
  );

  modport slave (
    input  clr, load, load_val, inc, dec, step, limit,
    output count, cout, tc, zero
  );
endinterface

// File: rtl/step_addsub.sv
// One-step add or subtract of the count against the 0..limit range, computed
// one bit wider than the counter so overflow and borrow are never truncated.
module step_addsub
  import step_counter_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int STEP_W   = 4,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0]  count,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic              dir_dn,
  output logic [WIDTH-1:0]  result,
  output logic              crossed
);
  localparam int XW = WIDTH + 1;

  logic [XW-1:0] cx, sx, lx, l1x, sum, wrap_up, base_dn;

  assign cx      = {1'b0, count};
  assign sx      = XW'(step);
  assign lx      = {1'b0, limit};
  assign l1x     = lx + XW'(1);
  assign sum     = cx + sx;
  assign wrap_up = sum - l1x;
  assign base_dn = cx + l1x;

  // A wrap that still lands outside 0..limit (step larger than the range) collapses to 0.
  always_comb begin
    result  = count;
    crossed = 1'b0;
    if (!dir_dn) begin
      if (sum <= lx) begin
        result = WIDTH'(sum);
      end else begin
        crossed = 1'b1;
        if (SATURATE == MODE_SAT)  result = limit;
        else if (wrap_up > lx)     result = '0;
        else                       result = WIDTH'(wrap_up);
      end
    end else begin
      if (cx >= sx) begin
        result = count - WIDTH'(step);
      end else begin
        crossed = 1'b1;
        if (SATURATE == MODE_SAT)  result = '0;
        else if (base_dn < sx)     result = '0;
        else                       result = WIDTH'(base_dn - sx);
      end
    end
  end

endmodule

// File: rtl/step_counter.sv
// Bounded up/down counter with programmable step: clr > load > inc^dec > hold.
module step_counter
  import step_counter_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int STEP_W   = 4,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic           clk,
  input  logic           rst_n,
  step_counter_if.slave  bus
);
  if (!params_ok(WIDTH, STEP_W, SATURATE)) begin : g_bad_params
    $error("step_counter: illegal WIDTH/STEP_W/SATURATE combination");
  end

  logic [WIDTH-1:0] count_q;
  logic             cout_q;
  logic [WIDTH-1:0] next_val;
  logic             crossed;
  logic             op_valid;

  step_addsub #(
    .WIDTH   (WIDTH),
    .STEP_W  (STEP_W),
    .SATURATE(SATURATE)
  ) u_addsub (
    .count  (count_q),
    .step   (bus.step),
    .limit  (bus.limit),
    .dir_dn (bus.dec),
    .result (next_val),
    .crossed(crossed)
  );

  // inc and dec together, or a zero step, is a hold with no carry.
  assign op_valid = (bus.inc ^ bus.dec) && (bus.step != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      cout_q  <= 1'b0;
    end else if (bus.clr) begin
      count_q <= '0;
      cout_q  <= 1'b0;
    end else if (bus.load) begin
      count_q <= (bus.load_val > bus.limit) ? bus.limit : bus.load_val;
      cout_q  <= 1'b0;
    end else if (op_valid) begin
      count_q <= next_val;
      cout_q  <= crossed;
    end else begin
      cout_q  <= 1'b0;
    end
  end

  assign bus.count = count_q;
  assign bus.cout  = cout_q;
  assign bus.tc    = (count_q == bus.limit);
  assign bus.zero  = (count_q == '0);

endmodule

// File: tb/tb_step_counter.sv
// Runs a wrapping and a saturating step_counter side by side against a behavioural model.
module tb_step_counter;
  logic        clk;
  logic        rst_n;
  logic        clr, load, inc, dec;
  logic [15:0] load_val, limit;
  logic [3:0]  step;

  int n_vec = 0;
  int n_err = 0;

  longint exp_cnt [2];
  bit     exp_cout[2];

  step_counter_if #(.WIDTH(16), .STEP_W(4)) ifw ();
  step_counter_if #(.WIDTH(16), .STEP_W(4)) ifs ();

  assign ifw.clr = clr;   assign ifs.clr = clr;
  assign ifw.load = load; assign ifs.load = load;
  assign ifw.load_val = load_val; assign ifs.load_val = load_val;
  assign ifw.inc = inc;   assign ifs.inc = inc;
  assign ifw.dec = dec;   assign ifs.dec = dec;
  assign ifw.step = step; assign ifs.step = step;
  assign ifw.limit = limit; assign ifs.limit = limit;

  step_counter #(.WIDTH(16), .STEP_W(4), .SATURATE(0)) dut_w (.clk(clk), .rst_n(rst_n), .bus(ifw.slave));
  step_counter #(.WIDTH(16), .STEP_W(4), .SATURATE(1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(ifs.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Range 0..lm; crossing upward either clamps or wraps by lm+1, out-of-range wrap lands on 0.
  function automatic void model(input int sat, input bit c, input bit l, input longint lv,
                                input bit i, input bit d, input longint st, input longint lm,
                                inout longint cnt, output bit co);
    longint s;
    co = 1'b0;
    if (c) cnt = 0;
    else if (l) cnt = (lv > lm) ? lm : lv;
    else if ((i != d) && (st != 0)) begin
      if (i) begin
        s = cnt + st;
        if (s <= lm) cnt = s;
        else begin
          co  = 1'b1;
          cnt = sat ? lm : ((s - (lm + 1) > lm) ? 0 : s - (lm + 1));
        end
      end else begin
        if (cnt >= st) cnt = cnt - st;
        else begin
          co  = 1'b1;
          s   = cnt + (lm + 1) - st;
          cnt = sat ? 0 : ((s < 0) ? 0 : s);
        end
      end
    end
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_w_cnt"},  ifw.count, 32'(exp_cnt[0]));
    check({tag, "_w_cout"}, ifw.cout,  32'(exp_cout[0]));
    check({tag, "_w_tc"},   ifw.tc,    32'(exp_cnt[0] == longint'(limit)));
    check({tag, "_w_zero"}, ifw.zero,  32'(exp_cnt[0] == 0));
    check({tag, "_s_cnt"},  ifs.count, 32'(exp_cnt[1]));
    check({tag, "_s_cout"}, ifs.cout,  32'(exp_cout[1]));
    check({tag, "_s_tc"},   ifs.tc,    32'(exp_cnt[1] == longint'(limit)));
    check({tag, "_s_zero"}, ifs.zero,  32'(exp_cnt[1] == 0));
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cyc(input string tag, input bit c, input bit l, input logic [15:0] lv,
                     input bit i, input bit d, input logic [3:0] st, input logic [15:0] lm);
    clr = c; load = l; load_val = lv; inc = i; dec = d; step = st; limit = lm;
    for (int m = 0; m < 2; m++)
      model(m, c, l, longint'(lv), i, d, longint'(st), longint'(lm), exp_cnt[m], exp_cout[m]);
    @(posedge clk);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  initial begin
    bit          r_clr, r_load, r_inc, r_dec;
    logic [15:0] r_lim, r_lv;
    logic [3:0]  r_step;

    rst_n = 1'b0;
    clr = 0; load = 0; load_val = '0; inc = 0; dec = 0; step = '0; limit = '0;
    exp_cnt[0] = 0; exp_cnt[1] = 0; exp_cout[0] = 0; exp_cout[1] = 0;
    #12;
    check("rst_cnt",  ifw.count, 32'h0);
    check("rst_cout", ifw.cout,  32'h0);
    check("rst_zero", ifw.zero,  32'h1);
    check("rst_tc_lim0", ifw.tc, 32'h1);
    limit = 16'hFFFF;
    #1;
    check("rst_tc_limff", ifw.tc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full-range wrap from FFFF
    cyc("ld_ffff", 0, 1, 16'hFFFF, 0, 0, 4'd0, 16'hFFFF);
    cyc("wrap_ff", 0, 0, 16'h0000, 1, 0, 4'd1, 16'hFFFF);
    check("r035_cnt",  ifw.count, 32'h0000);
    check("r035_cout", ifw.cout,  32'h1);
    check("r035_zero", ifw.zero,  32'h1);
    cyc("wrap_hold", 0, 0, 16'h0000, 0, 0, 4'd1, 16'hFFFF);
    check("r035_cout_drop", ifw.cout, 32'h0);

    // Small-limit wrap up then down
    cyc("ld_8", 0, 1, 16'h0008, 0, 0, 4'd0, 16'h0009);
    cyc("inc3", 0, 0, 16'h0000, 1, 0, 4'd3, 16'h0009);
    check("r036_up_cnt",  ifw.count, 32'h0001);
    check("r036_up_cout", ifw.cout,  32'h1);
    cyc("dec2", 0, 0, 16'h0000, 0, 1, 4'd2, 16'h0009);
    check("r036_dn_cnt",  ifw.count, 32'h0009);
    check("r036_dn_cout", ifw.cout,  32'h1);
    check("r036_dn_tc",   ifw.tc,    32'h1);

    // Saturating clamps, back-to-back carries
    cyc("ld_fe", 0, 1, 16'h00FE, 0, 0, 4'd0, 16'h00FF);
    cyc("sat_up1", 0, 0, 16'h0000, 1, 0, 4'd5, 16'h00FF);
    check("r037_up1_cnt",  ifs.count, 32'h00FF);
    check("r037_up1_cout", ifs.cout,  32'h1);
    cyc("sat_up2", 0, 0, 16'h0000, 1, 0, 4'd5, 16'h00FF);
    check("r037_up2_cnt",  ifs.count, 32'h00FF);
    check("r037_up2_cout", ifs.cout,  32'h1);
    cyc("ld_2", 0, 1, 16'h0002, 0, 0, 4'd0, 16'h00FF);
    cyc("sat_dn", 0, 0, 16'h0000, 0, 1, 4'd7, 16'h00FF);
    check("r037_dn_cnt",  ifs.count, 32'h0000);
    check("r037_dn_cout", ifs.cout,  32'h1);

    // Priority
    cyc("ld_55", 0, 1, 16'h0055, 0, 0, 4'd0, 16'h0100);
    cyc("pri_clr", 1, 1, 16'h0077, 1, 0, 4'd3, 16'h0100);
    check("r038_clr", ifw.count, 32'h0);
    cyc("pri_ld", 0, 1, 16'h1234, 1, 0, 4'd3, 16'h0100);
    check("r038_ld_cnt",  ifw.count, 32'h0100);
    check("r038_ld_cout", ifw.cout,  32'h0);
    cyc("pri_both", 0, 0, 16'h0000, 1, 1, 4'd3, 16'h0100);
    check("r038_both", ifw.count, 32'h0100);

    // Oversized step relative to a tiny range, and a lowered limit
    cyc("ld_1", 0, 1, 16'h0001, 0, 0, 4'd0, 16'h0002);
    cyc("big_up", 0, 0, 16'h0000, 1, 0, 4'd9, 16'h0002);
    check("r025_up", ifw.count, 32'h0);
    cyc("big_dn", 0, 0, 16'h0000, 0, 1, 4'd9, 16'h0002);
    check("r025_dn", ifw.count, 32'h0);
    cyc("ld_40", 0, 1, 16'h0040, 0, 0, 4'd0, 16'h0080);
    cyc("low_inc", 0, 0, 16'h0000, 1, 0, 4'd1, 16'h0010);
    check("r026_cout", ifw.cout, 32'h1);

    // Asynchronous reset between edges
    cyc("ld_abcd", 0, 1, 16'hABCD, 0, 0, 4'd0, 16'hFFFF);
    inc = 1; dec = 0; load = 0; step = 4'd1;
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt[0] = 0; exp_cnt[1] = 0; exp_cout[0] = 0; exp_cout[1] = 0;
    check("r039_cnt",  ifw.count, 32'h0);
    check("r039_cout", ifw.cout,  32'h0);
    check("r039_zero", ifw.zero,  32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("rst_resume", 0, 0, 16'h0000, 1, 0, 4'd1, 16'hFFFF);
    check("r039_resume", ifw.count, 32'h1);

    // Randomized run, both modes in parallel
    r_lim = 16'h0010;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 3))
          0: r_lim = 16'($urandom_range(0, 20));
          1: r_lim = 16'hFFFF;
          2: r_lim = 16'($urandom);
          default: r_lim = 16'($urandom_range(0, 3));
        endcase
      end
      r_clr  = ($urandom_range(0, 99) == 0);
      r_load = ($urandom_range(0, 19) == 0);
      r_inc  = 1'($urandom_range(0, 1));
      r_dec  = 1'($urandom_range(0, 1));
      r_step = 4'($urandom_range(0, 15));
      r_lv   = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 24)) : 16'($urandom);
      cyc("rnd", r_clr, r_load, r_lv, r_inc, r_dec, r_step, r_lim);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
